// File: rtl/pry2oht_tree.sv
// Priority-to-one-hot converter: keeps only the highest-priority set bit of pry and flags any-set.
// Latency: 1 core clock; a new pry is accepted every cycle, output register only.
// Backpressure: none; free-running, no handshake.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset (release synchronous to clk)
//   pry    in   WIDTH  priority request vector
//   oht    out  WIDTH  registered one-hot of the highest-priority set bit of pry
//   vld    out  1      registered |pry
//
// The tree is built bottom-up: level l combines groups of SPLIT**l bits in
// SPLIT-wide clusters. The result is the same as the top-down recursion. Each
// cluster runs the base cell over its children's valid flags. It then masks the
// losing children's one-hot slices to zero. The MSB direction reuses the LSB
// tree by reversing the bit order on both sides.
module pry2oht_tree #(
    parameter int WIDTH          = 32,
    parameter int SPLIT          = 2,
    parameter int IMPLEMENTATION = 0,
    parameter     DIRECTION      = "LSB"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    // Number of tree levels k with WIDTH == SPLIT**k; -1 when no such k exists.
    function automatic int calc_levels(input int w, input int s);
        int n;
        int lv;
        n  = w;
        lv = 0;
        if (s < 2) begin
            return -1;
        end
        while (n > 1 && (n % s) == 0) begin
            n  = n / s;
            lv = lv + 1;
        end
        return (n == 1) ? lv : -1;
    endfunction

    localparam int LEVELS    = calc_levels(WIDTH, SPLIT);
    localparam int LV        = (LEVELS < 1) ? 1 : LEVELS;
    localparam bit MSB_FIRST = (DIRECTION == "MSB");

    if (LEVELS < 1) begin : g_bad_geom
        $error("pry2oht_tree: WIDTH (%0d) must equal SPLIT (%0d) ** k with k >= 1 and SPLIT >= 2",
               WIDTH, SPLIT);
    end
    if (DIRECTION != "LSB" && DIRECTION != "MSB") begin : g_bad_dir
        $error("pry2oht_tree: DIRECTION must be \"LSB\" or \"MSB\"");
    end

    // Base cell; bit 0 has the highest priority.
    // Both forms AND each request with "nothing of higher priority is set". Once
    // a 1 is found, every lower-priority result is forced to 0 regardless of
    // that bit's value. This keeps X/Z in losing bits from reaching the outputs.
    function automatic logic [SPLIT-1:0] base_cell(input logic [SPLIT-1:0] p);
        logic [SPLIT-1:0] r;
        logic             seen;
        logic             hi;
        r    = '0;
        seen = 1'b0;
        hi   = 1'b0;
        if (IMPLEMENTATION == 0) begin
            // ripple chain from the priority end
            for (int i = 0; i < SPLIT; i++) begin
                r[i] = p[i] & ~seen;
                seen = seen | p[i];
            end
        end else begin
            // independent mask per bit: OR of all higher-priority requests
            for (int i = 0; i < SPLIT; i++) begin
                hi = 1'b0;
                for (int j = 0; j < i; j++) begin
                    hi = hi | p[j];
                end
                r[i] = p[i] & ~hi;
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] p_lsb;
    logic [WIDTH-1:0] oht_lsb;
    logic [WIDTH-1:0] oht_d;
    logic             vld_d;
    logic [WIDTH-1:0] oht_q;
    logic             vld_q;

    // Normalise to "bit 0 wins" so that one tree serves both directions.
    for (genvar b = 0; b < WIDTH; b++) begin : g_dir
        if (MSB_FIRST) begin : g_rev
            assign p_lsb[b] = pry[WIDTH-1-b];
            assign oht_d[b] = oht_lsb[WIDTH-1-b];
        end else begin : g_fwd
            assign p_lsb[b] = pry[b];
            assign oht_d[b] = oht_lsb[b];
        end
    end

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int G  = SPLIT ** l;           // bits per child at this level
        localparam int NG = WIDTH / (G * SPLIT);  // clusters at this level

        logic [WIDTH-1:0]      oht_in;
        logic [NG*SPLIT-1:0]   v_in;
        logic [WIDTH-1:0]      oht_l;
        logic [NG-1:0]         v_l;

        // At the leaves every bit is its own child: one-hot and valid are the request itself.
        if (l == 0) begin : g_first
            assign oht_in = p_lsb;
            assign v_in   = p_lsb;
        end else begin : g_next
            assign oht_in = g_lvl[l-1].oht_l;
            assign v_in   = g_lvl[l-1].v_l;
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [SPLIT-1:0] sub;
            logic [SPLIT-1:0] sel;

            assign sub    = v_in[g*SPLIT +: SPLIT];
            assign sel    = base_cell(sub);
            assign v_l[g] = |sub;

            for (genvar j = 0; j < SPLIT; j++) begin : g_child
                assign oht_l[(g*SPLIT+j)*G +: G] = oht_in[(g*SPLIT+j)*G +: G] & {G{sel[j]}};
            end
        end
    end

    assign oht_lsb = g_lvl[LV-1].oht_l;
    assign vld_d   = g_lvl[LV-1].v_l[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oht_q <= '0;
            vld_q <= 1'b0;
        end else begin
            oht_q <= oht_d;
            vld_q <= vld_d;
        end
    end

    assign oht = oht_q;
    assign vld = vld_q;

endmodule

// File: tb/tb_pry2oht_tree.sv
// Bench for pry2oht_tree: three instances see the same pry stream.
// The instances are LSB ripple, LSB parallel-mask and MSB ripple, each checked one cycle late.
// Expected values come from arithmetic models: p & -p, or a scan for the top set bit.
module tb_pry2oht_tree;

    logic        clk;
    logic        rst_n;
    logic [31:0] pry;
    logic [31:0] oht0, oht1, oht2;
    logic        vld0, vld1, vld2;

    int total = 0;
    int bad   = 0;

    pry2oht_tree #(.WIDTH(32), .SPLIT(2), .IMPLEMENTATION(0), .DIRECTION("LSB")) dut0 (
        .clk(clk), .rst_n(rst_n), .pry(pry), .oht(oht0), .vld(vld0));
    pry2oht_tree #(.WIDTH(32), .SPLIT(2), .IMPLEMENTATION(1), .DIRECTION("LSB")) dut1 (
        .clk(clk), .rst_n(rst_n), .pry(pry), .oht(oht1), .vld(vld1));
    pry2oht_tree #(.WIDTH(32), .SPLIT(2), .IMPLEMENTATION(0), .DIRECTION("MSB")) dut2 (
        .clk(clk), .rst_n(rst_n), .pry(pry), .oht(oht2), .vld(vld2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lsb_model(input logic [31:0] p);
        return p & (~p + 32'd1);
    endfunction

    function automatic logic [31:0] msb_model(input logic [31:0] p);
        for (int i = 31; i >= 0; i--) begin
            if (p[i]) return 32'd1 << i;
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge, let one rising edge capture it, then check at the next falling edge.
    // p_clean is the 0/1 meaning of p_drive for the LSB checks. X-laden vectors skip the MSB instance.
    task automatic step(input string tag, input logic [31:0] p_drive,
                        input logic [31:0] p_clean, input bit do_msb);
        pry = p_drive;
        @(negedge clk);
        chk({tag, ".oht0"}, oht0, lsb_model(p_clean));
        chk({tag, ".vld0"}, {31'd0, vld0}, {31'd0, p_clean != 0});
        chk({tag, ".oht1"}, oht1, lsb_model(p_clean));
        chk({tag, ".vld1"}, {31'd0, vld1}, {31'd0, p_clean != 0});
        if (do_msb) begin
            chk({tag, ".oht2"}, oht2, msb_model(p_clean));
            chk({tag, ".vld2"}, {31'd0, vld2}, {31'd0, p_clean != 0});
        end
    endtask

    initial begin
        logic [31:0] pd;
        logic [31:0] pc;
        logic [31:0] v;

        // power-on reset
        rst_n = 1'b0;
        pry   = 32'd0;
        #1;
        chk("rst0.oht0", oht0, 32'd0);
        chk("rst0.oht1", oht1, 32'd0);
        chk("rst0.oht2", oht2, 32'd0);
        chk("rst0.vld", {29'd0, vld0, vld1, vld2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle
        step("idle", 32'd0, 32'd0, 1'b1);

        // one-hot sweep
        for (int i = 0; i < 32; i++) begin
            pc = 32'd1 << i;
            step($sformatf("sweep%0d", i), pc, pc, 1'b1);
        end

        // directed MSB cases, with fixed expectations
        pry = 32'h0000_00F0;
        @(negedge clk);
        chk("msb_f0", oht2, 32'h0000_0080);
        chk("msb_f0.lsb", oht0, 32'h0000_0010);
        pry = 32'h8000_0001;
        @(negedge clk);
        chk("msb_ends", oht2, 32'h8000_0000);
        chk("msb_ends.lsb", oht1, 32'h0000_0001);

        // priority with unknown bits above the winner
        for (int i = 0; i < 32; i++) begin
            pd = 32'd0;
            pd[i] = 1'b1;
            for (int j = i + 1; j < 32; j++) pd[j] = 1'bx;
            step($sformatf("xiso%0d", i), pd, 32'd1 << i, 1'b0);
        end

        // mid-run asynchronous reset with all requests set
        step("pre_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async.oht0", oht0, 32'd0);
        chk("rst_async.oht1", oht1, 32'd0);
        chk("rst_async.oht2", oht2, 32'd0);
        chk("rst_async.vld", {29'd0, vld0, vld1, vld2}, 32'd0);
        @(negedge clk);
        chk("rst_hold.oht0", oht0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel.oht0", oht0, 32'h0000_0001);
        chk("rst_rel.oht1", oht1, 32'h0000_0001);
        chk("rst_rel.oht2", oht2, 32'h8000_0000);
        chk("rst_rel.vld", {29'd0, vld0, vld1, vld2}, 32'd7);

        // descending head of the bit-reversed count, then a random subset
        for (int k = 0; k < 64; k++) begin
            pc = bitrev(32'hFFFF_FFFF - k);
            step("rev_desc", pc, pc, 1'b1);
        end
        for (int k = 0; k < 300; k++) begin
            v = $urandom;
            if (k % 2 == 1) v = v & $urandom & $urandom;
            if (v == 32'd0) v = 32'd1;
            pc = bitrev(v);
            step("rev_rand", pc, pc, 1'b1);
        end

        step("idle_end", 32'd0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
